// File: rtl/kypd_scan_ctrl_if.sv
// Key event handshake between the keypad scanner and its consumer.
// The scanner owns valid/code/press; the consumer owns ready.
interface kypd_scan_ctrl_if;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] key_code;
  logic       key_press;

  modport master (output key_valid, output key_code, output key_press, input key_ready);
  modport slave  (input key_valid, input key_code, input key_press, output key_ready);
endinterface

// File: rtl/kypd_scan_ctrl.sv
// 4x4 keypad column scanner with frame-based debounce, single-key commit
// and a one-entry press/release event buffer with sticky overflow.
//
// state   | meaning
// ST_IDLE | scanning stopped, columns released, restart at column 0 next
// ST_SCAN | driving one column per dwell, classifying a frame every 4 columns
module kypd_scan_ctrl #(
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic                    clk,
  input  logic                    sys_rst,
  input  logic                    scan_en,
  input  logic [3:0]              Row,
  output logic [3:0]              Col,
  kypd_scan_ctrl_if.master        evt,
  output logic                    key_held,
  output logic [3:0]              held_code,
  output logic                    ovf,
  input  logic                    ovf_clr
);

  localparam int             DW         = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]     DEB        = 4'(DEBOUNCE_FRAMES);

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  state_t        r_state;
  logic [3:0]    r_row_s1, r_row_s2;
  logic [3:0]    r_col;
  logic [1:0]    r_col_idx;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_hits;
  logic [3:0]    r_frame_code;
  logic          r_cand_key;
  logic [3:0]    r_cand_code;
  logic [3:0]    r_cnt;
  logic          r_held;
  logic [3:0]    r_held_code;
  logic          r_valid;
  logic [3:0]    r_code;
  logic          r_press;
  logic          r_ovf;

  logic [3:0] w_lows;
  logic [2:0] w_col_n;
  logic [2:0] w_tot;
  logic [1:0] w_row_idx;
  logic [3:0] w_col_code;
  logic       w_col_end, w_frame_end, w_multi;
  logic       w_res_key;
  logic [3:0] w_res_code;
  logic       w_match, w_differ, w_commit;
  logic [3:0] w_cnt_next;
  logic       w_pop;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
      4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
      4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
      4'hC: key_map = 4'h0;  4'hD: key_map = 4'hF;  4'hE: key_map = 4'hE;  default: key_map = 4'hD;
    endcase
  endfunction

  always_comb begin
    w_lows    = ~r_row_s2;
    w_col_n   = {2'b0, w_lows[0]} + {2'b0, w_lows[1]} + {2'b0, w_lows[2]} + {2'b0, w_lows[3]};
    w_tot     = {1'b0, r_hits} + w_col_n;
    w_row_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (w_lows[3-i]) w_row_idx = 2'(i);
    end
    w_col_code  = key_map(w_row_idx, r_col_idx);
    w_col_end   = scan_en && (r_state == ST_SCAN) && (r_dwell == '0);
    w_frame_end = w_col_end && (r_col_idx == 2'd3);
    w_multi     = (w_tot > 3'd1);
    w_res_key   = (w_tot == 3'd1);
    w_res_code  = 4'h0;
    if (w_res_key) w_res_code = (r_hits == 2'd1) ? r_frame_code : w_col_code;
    w_match     = (w_res_key == r_cand_key) && (w_res_code == r_cand_code);
    w_cnt_next  = 4'd1;
    if (w_match) w_cnt_next = (r_cnt >= DEB) ? DEB : r_cnt + 4'd1;
    w_differ    = (w_res_key != r_held) || (w_res_key && (w_res_code != r_held_code));
    w_commit    = w_frame_end && !w_multi && (w_cnt_next == DEB) && w_differ;
    w_pop       = r_valid && evt.key_ready;
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_state      <= ST_IDLE;
      r_row_s1     <= 4'hF;
      r_row_s2     <= 4'hF;
      r_col        <= 4'hF;
      r_col_idx    <= 2'd0;
      r_dwell      <= DWELL_LAST;
      r_hits       <= 2'd0;
      r_frame_code <= 4'h0;
      r_cand_key   <= 1'b0;
      r_cand_code  <= 4'h0;
      r_cnt        <= 4'd0;
      r_held       <= 1'b0;
      r_held_code  <= 4'h0;
      r_valid      <= 1'b0;
      r_code       <= 4'h0;
      r_press      <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_row_s1 <= Row;
      r_row_s2 <= r_row_s1;

      // A release while held is emitted before any press of a different key.
      if (w_commit && (!r_valid || w_pop)) begin
        r_valid <= 1'b1;
        r_code  <= r_held ? r_held_code : w_res_code;
        r_press <= !r_held;
      end else if (w_pop) begin
        r_valid <= 1'b0;
      end

      if (w_commit && r_valid && !w_pop) r_ovf <= 1'b1;
      else if (ovf_clr)                  r_ovf <= 1'b0;

      if (!scan_en) begin
        r_state      <= ST_IDLE;
        r_col        <= 4'hF;
        r_col_idx    <= 2'd0;
        r_dwell      <= DWELL_LAST;
        r_hits       <= 2'd0;
        r_frame_code <= 4'h0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state      <= ST_SCAN;
            r_col        <= 4'b0111;
            r_col_idx    <= 2'd0;
            r_dwell      <= DWELL_LAST;
            r_hits       <= 2'd0;
            r_frame_code <= 4'h0;
          end
          default: begin
            if (r_dwell != '0) begin
              r_dwell <= r_dwell - 1'b1;
            end else begin
              r_dwell   <= DWELL_LAST;
              r_col_idx <= r_col_idx + 2'd1;
              r_col     <= {r_col[0], r_col[3:1]};
              if (r_col_idx == 2'd3) begin
                r_hits       <= 2'd0;
                r_frame_code <= 4'h0;
                if (!w_multi) begin
                  r_cand_key  <= w_res_key;
                  r_cand_code <= w_res_code;
                  r_cnt       <= w_cnt_next;
                end
                if (w_commit) begin
                  r_held      <= !r_held;
                  r_held_code <= r_held ? 4'h0 : w_res_code;
                end
              end else begin
                r_hits <= w_multi ? 2'd2 : w_tot[1:0];
                if (r_hits == 2'd0 && w_col_n == 3'd1) r_frame_code <= w_col_code;
              end
            end
          end
        endcase
      end
    end
  end

  assign Col           = r_col;
  assign evt.key_valid = r_valid;
  assign evt.key_code  = r_code;
  assign evt.key_press = r_press;
  assign key_held      = r_held;
  assign held_code     = r_held_code;
  assign ovf           = r_ovf;

endmodule

// File: tb/tb_kypd_scan_ctrl.sv
// Directed bench for kypd_scan_ctrl with SCAN_DIV=4, DEBOUNCE_FRAMES=2:
// a frame is 16 cycles, frame k ends on edge 1+16k after reset release.
module tb_kypd_scan_ctrl;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        scan_en;
  logic [3:0]  row_w;
  logic [3:0]  col_w;
  logic        key_held;
  logic [3:0]  held_code;
  logic        ovf;
  logic        ovf_clr;
  logic [15:0] keys;
  int          n_checks = 0;
  int          n_errors = 0;
  int          ed = 0;

  kypd_scan_ctrl_if evt_if ();

  kypd_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(2)) dut (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .scan_en   (scan_en),
    .Row       (row_w),
    .Col       (col_w),
    .evt       (evt_if),
    .key_held  (key_held),
    .held_code (held_code),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  // Keypad matrix: key (r,c) = keys[r*4+c] pulls Row[3-r] low while Col[3-c] is low.
  always_comb begin
    row_w = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_w[3-c]) row_w[3-r] = 1'b0;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
    ed += n;
  endtask

  task automatic goto_edge(input int e);
    step(e - ed);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input logic [15:0] k);
    sys_rst = 1'b1;
    keys    = k;
    step(1);
    chk("rst_col",       col_w,            4'hF);
    chk("rst_valid",     evt_if.key_valid, 4'h0);
    chk("rst_code",      evt_if.key_code,  4'h0);
    chk("rst_press",     evt_if.key_press, 4'h0);
    chk("rst_held",      key_held,         4'h0);
    chk("rst_held_code", held_code,        4'h0);
    chk("rst_ovf",       ovf,              4'h0);
    step(2);
    sys_rst = 1'b0;
    ed = 0;
  endtask

  initial begin
    sys_rst          = 1'b1;
    scan_en          = 1'b1;
    keys             = 16'h0;
    ovf_clr          = 1'b0;
    evt_if.key_ready = 1'b1;

    // Key "5" (r1,c1): press commits at frame 2, release after two NONE frames.
    do_reset(16'h0020);
    step(1);
    chk("col_first", col_w, 4'b0111);
    goto_edge(5);
    chk("col_second", col_w, 4'b1011);
    goto_edge(17);
    chk("col_wrap", col_w, 4'b0111);
    goto_edge(32);
    chk("p5_valid_before", evt_if.key_valid, 4'h0);
    chk("p5_held_before",  key_held,         4'h0);
    goto_edge(33);
    chk("p5_valid", evt_if.key_valid, 4'h1);
    chk("p5_code",  evt_if.key_code,  4'h5);
    chk("p5_press", evt_if.key_press, 4'h1);
    chk("p5_held",  key_held,         4'h1);
    chk("p5_hcode", held_code,        4'h5);
    goto_edge(34);
    chk("p5_popped", evt_if.key_valid, 4'h0);
    goto_edge(49);
    keys = 16'h0;
    goto_edge(80);
    chk("r5_held_before", key_held, 4'h1);
    goto_edge(81);
    chk("r5_valid", evt_if.key_valid, 4'h1);
    chk("r5_code",  evt_if.key_code,  4'h5);
    chk("r5_press", evt_if.key_press, 4'h0);
    chk("r5_held",  key_held,         4'h0);
    chk("r5_hcode", held_code,        4'h0);

    // Direct change "1" -> "D": release 1, then press D one frame later.
    do_reset(16'h0001);
    goto_edge(33);
    chk("p1_code", evt_if.key_code, 4'h1);
    chk("p1_held", key_held,        4'h1);
    keys = 16'h8000;
    goto_edge(64);
    chk("chg_held_before", key_held, 4'h1);
    goto_edge(65);
    chk("chg_rel_valid", evt_if.key_valid, 4'h1);
    chk("chg_rel_code",  evt_if.key_code,  4'h1);
    chk("chg_rel_press", evt_if.key_press, 4'h0);
    chk("chg_rel_held",  key_held,         4'h0);
    goto_edge(80);
    chk("chg_gap_valid", evt_if.key_valid, 4'h0);
    chk("chg_gap_held",  key_held,         4'h0);
    goto_edge(81);
    chk("chg_pD_valid", evt_if.key_valid, 4'h1);
    chk("chg_pD_code",  evt_if.key_code,  4'hD);
    chk("chg_pD_press", evt_if.key_press, 4'h1);
    chk("chg_pD_hcode", held_code,        4'hD);

    // Stalled consumer: press "A" stays buffered, its release is dropped.
    evt_if.key_ready = 1'b0;
    do_reset(16'h0008);
    goto_edge(33);
    chk("pA_valid", evt_if.key_valid, 4'h1);
    chk("pA_code",  evt_if.key_code,  4'hA);
    keys = 16'h0;
    goto_edge(64);
    chk("ovf_before", ovf, 4'h0);
    goto_edge(65);
    chk("ovf_set",      ovf,              4'h1);
    chk("ovf_valid",    evt_if.key_valid, 4'h1);
    chk("ovf_code",     evt_if.key_code,  4'hA);
    chk("ovf_press",    evt_if.key_press, 4'h1);
    chk("ovf_held",     key_held,         4'h0);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("ovf_cleared", ovf, 4'h0);
    evt_if.key_ready = 1'b1;
    step(1);
    chk("ovf_pop", evt_if.key_valid, 4'h0);

    // "2" committed, then "6" added: MULTI frames leave everything alone.
    do_reset(16'h0002);
    goto_edge(33);
    chk("p2_hcode", held_code, 4'h2);
    keys = 16'h0042;
    goto_edge(81);
    chk("multi_held",  key_held,         4'h1);
    chk("multi_hcode", held_code,        4'h2);
    chk("multi_valid", evt_if.key_valid, 4'h0);
    keys = 16'h0002;
    goto_edge(97);
    chk("multi_after_valid", evt_if.key_valid, 4'h0);
    chk("multi_after_held",  key_held,         4'h1);
    scan_en = 1'b0;
    step(1);
    chk("dis_col", col_w, 4'hF);
    scan_en = 1'b1;
    step(1);
    chk("en_col",   col_w,     4'b0111);
    chk("en_hcode", held_code, 4'h2);

    // Reset mid-frame with a press event pending.
    evt_if.key_ready = 1'b0;
    do_reset(16'h0020);
    goto_edge(40);
    chk("pend_valid", evt_if.key_valid, 4'h1);
    do_reset(16'h0020);
    step(1);
    chk("post_rst_col", col_w, 4'b0111);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
